demux_select: RTL and testbench

//  Registered 1-to-8 demultiplexer: steers a 4-bit word to one of eight channel registers chosen by a 3-bit flag.

---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_scan_fsm.sv | 93 +++++++++
 rtl/demux_select.sv | 111 +++++++++++
 tb/tb_demux_select.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and scan-state encoding for the demux_select write/readback slice.
package demux_pkg;

  localparam int unsigned DW  = 4;
  localparam int unsigned NCH = 8;

  localparam logic [2:0] LAST_IDX = 3'd7;
  localparam logic [7:0] OVW_MAX  = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/demux_scan_fsm.sv
// Readback scanner: walks channel indices 0..7, one per cycle, then pulses done.
// Also owns the write-side in_ready, which is held low for the whole scan.
module demux_scan_fsm
  import demux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_clr,
  output logic       o_in_ready,
  output logic       o_rd_valid,
  output logic [2:0] o_rd_sel,
  output logic       o_rd_done,
  output logic       o_load,
  output logic [2:0] o_load_idx
);

  scan_state_t r_state;
  logic [2:0]  r_idx;
  logic        r_rd_valid;
  logic        r_rd_done;
  logic        r_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_done  <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (i_clr) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_done  <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rd_done <= 1'b0;
          if (i_start) begin
            r_state    <= ST_SCAN;
            r_idx      <= '0;
            r_rd_valid <= 1'b1;
            r_in_ready <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (r_idx == LAST_IDX) begin
            r_state    <= ST_DONE;
            r_rd_valid <= 1'b0;
            r_rd_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_rd_done  <= 1'b0;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_rd_valid <= 1'b0;
          r_rd_done  <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Tells the register file which channel to capture into rd_data on this edge,
  // so rd_data lines up with the registered rd_sel.
  always_comb begin
    o_load     = 1'b0;
    o_load_idx = '0;
    if (!i_clr) begin
      if (r_state == ST_IDLE && i_start) begin
        o_load     = 1'b1;
        o_load_idx = '0;
      end else if (r_state == ST_SCAN && r_idx != LAST_IDX) begin
        o_load     = 1'b1;
        o_load_idx = r_idx + 3'd1;
      end
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_sel   = r_idx;
  assign o_rd_done  = r_rd_done;

endmodule

// File: rtl/demux_select.sv
// Registered 1-to-8 demux with channel register file and readback scan.
// Optional status outputs (wr_mask, ovw_cnt) enabled by DEMUX_STATUS_EN.
module demux_select
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     in_data,
  input  logic [2:0]        flag,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr,
  output logic [NCH*DW-1:0] out_bus,
  output logic [NCH-1:0]    out_upd,
  input  logic              scan_start,
  output logic              rd_valid,
  output logic [2:0]        rd_sel,
  output logic [DW-1:0]     rd_data,
  output logic              rd_done
`ifdef DEMUX_STATUS_EN
  ,
  output logic [NCH-1:0]    wr_mask,
  output logic [7:0]        ovw_cnt
`endif
);

  logic [DW-1:0]  r_ch     [NCH];
  logic [DW-1:0]  w_ch_nxt [NCH];
  logic [NCH-1:0] r_upd;
  logic [NCH-1:0] w_upd_nxt;
  logic [DW-1:0]  r_rd_data;
  logic           w_in_ready;
  logic           w_wr;
  logic           w_load;
  logic [2:0]     w_load_idx;

  demux_scan_fsm u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (scan_start),
    .i_clr      (clr),
    .o_in_ready (w_in_ready),
    .o_rd_valid (rd_valid),
    .o_rd_sel   (rd_sel),
    .o_rd_done  (rd_done),
    .o_load     (w_load),
    .o_load_idx (w_load_idx)
  );

  assign w_wr = in_valid && w_in_ready && !clr;

  // Next-state view of the register file; readback samples it so a write on
  // the scan-start edge is already visible in channel 0's readback.
  always_comb begin
    w_upd_nxt = '0;
    for (int unsigned k = 0; k < NCH; k++) w_ch_nxt[k] = r_ch[k];
    if (clr) begin
      for (int unsigned k = 0; k < NCH; k++) w_ch_nxt[k] = '0;
    end else if (w_wr) begin
      w_ch_nxt[flag]  = in_data;
      w_upd_nxt[flag] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NCH; k++) r_ch[k] <= '0;
      r_upd     <= '0;
      r_rd_data <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) r_ch[k] <= w_ch_nxt[k];
      r_upd <= w_upd_nxt;
      if (clr)
        r_rd_data <= '0;
      else if (w_load)
        r_rd_data <= w_ch_nxt[w_load_idx];
    end
  end

  always_comb begin
    out_bus = '0;
    for (int unsigned k = 0; k < NCH; k++) out_bus[k*DW +: DW] = r_ch[k];
  end

  assign out_upd  = r_upd;
  assign in_ready = w_in_ready;
  assign rd_data  = r_rd_data;

`ifdef DEMUX_STATUS_EN
  logic [NCH-1:0] r_wr_mask;
  logic [7:0]     r_ovw_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_mask <= '0;
      r_ovw_cnt <= '0;
    end else if (clr) begin
      r_wr_mask <= '0;
      r_ovw_cnt <= '0;
    end else if (w_wr) begin
      r_wr_mask[flag] <= 1'b1;
      if (r_wr_mask[flag] && r_ovw_cnt != OVW_MAX)
        r_ovw_cnt <= r_ovw_cnt + 8'd1;
    end
  end

  assign wr_mask = r_wr_mask;
  assign ovw_cnt = r_ovw_cnt;
`endif

endmodule

// File: tb/tb_demux_select.sv
// Directed testbench for demux_select; status checks compiled when DEMUX_STATUS_EN is defined.
module tb_demux_select;
  import demux_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [DW-1:0]     in_data;
  logic [2:0]        flag;
  logic              in_valid;
  logic              in_ready;
  logic              clr;
  logic [NCH*DW-1:0] out_bus;
  logic [NCH-1:0]    out_upd;
  logic              scan_start;
  logic              rd_valid;
  logic [2:0]        rd_sel;
  logic [DW-1:0]     rd_data;
  logic              rd_done;
`ifdef DEMUX_STATUS_EN
  logic [NCH-1:0]    wr_mask;
  logic [7:0]        ovw_cnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  demux_select dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .flag       (flag),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clr        (clr),
    .out_bus    (out_bus),
    .out_upd    (out_upd),
    .scan_start (scan_start),
    .rd_valid   (rd_valid),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .rd_done    (rd_done)
`ifdef DEMUX_STATUS_EN
    ,
    .wr_mask    (wr_mask),
    .ovw_cnt    (ovw_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_bus"},   out_bus,  32'h0);
    chk({tag, "_upd"},   out_upd,  32'h0);
    chk({tag, "_rdy"},   in_ready, 32'h1);
    chk({tag, "_rv"},    rd_valid, 32'h0);
    chk({tag, "_rsel"},  rd_sel,   32'h0);
    chk({tag, "_rdat"},  rd_data,  32'h0);
    chk({tag, "_rdone"}, rd_done,  32'h0);
  endtask

  initial begin
    logic seen_done;
    rst_n = 1'b0; in_data = '0; flag = '0; in_valid = 1'b0;
    clr = 1'b0; scan_start = 1'b0;
    #12;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();

    // 1: single write to channel 3
    in_valid = 1'b1; flag = 3'd3; in_data = 4'hA;
    step();
    in_valid = 1'b0;
    chk("t1_bus", out_bus, 32'h0000_A000);
    chk("t1_upd", out_upd, 32'h08);
    step();
    chk("t1_upd_clear", out_upd, 32'h0);

    // 2: fill channels with k+1, then scan
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; flag = 3'(k); in_data = 4'(k + 1);
      step();
      chk($sformatf("t2_upd%0d", k), out_upd, 32'(1 << k));
    end
    in_valid = 1'b0;
    chk("t2_bus", out_bus, 32'h8765_4321);
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_rv%0d", i),   rd_valid, 32'h1);
      chk($sformatf("t2_sel%0d", i),  rd_sel,   32'(i));
      chk($sformatf("t2_dat%0d", i),  rd_data,  32'(i + 1));
      chk($sformatf("t2_rdy%0d", i),  in_ready, 32'h0);
      chk($sformatf("t2_done%0d", i), rd_done,  32'h0);
      step();
    end
    chk("t2_done",      rd_done,  32'h1);
    chk("t2_done_rv",   rd_valid, 32'h0);
    chk("t2_done_rdy",  in_ready, 32'h0);
    step();
    chk("t2_after_done", rd_done,  32'h0);
    chk("t2_after_rdy",  in_ready, 32'h1);

    // 3: write held during scan is blocked until IDLE
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    in_valid = 1'b1; flag = 3'd5; in_data = 4'hF;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_upd%0d", i), out_upd, 32'h0);
      chk($sformatf("t3_dat%0d", i), rd_data, 32'(i + 1));
      step();
    end
    chk("t3_done",     rd_done, 32'h1);
    chk("t3_done_upd", out_upd, 32'h0);
    step();
    chk("t3_idle_rdy", in_ready, 32'h1);
    chk("t3_idle_upd", out_upd,  32'h0);
    chk("t3_idle_bus", out_bus,  32'h8765_4321);
    step();
    in_valid = 1'b0;
    chk("t3_accept_upd", out_upd, 32'h20);
    chk("t3_accept_bus", out_bus, 32'h87F5_4321);

    // same-value rewrite still strobes
    in_valid = 1'b1; flag = 3'd5; in_data = 4'hF;
    step();
    in_valid = 1'b0;
    chk("rewrite_upd", out_upd, 32'h20);
    chk("rewrite_bus", out_bus, 32'h87F5_4321);

    // write to ch0 on the scan-start edge shows up in readback
    in_valid = 1'b1; flag = 3'd0; in_data = 4'h9; scan_start = 1'b1;
    step();
    in_valid = 1'b0; scan_start = 1'b0;
    chk("bypass_upd", out_upd,  32'h01);
    chk("bypass_rv",  rd_valid, 32'h1);
    chk("bypass_sel", rd_sel,   32'h0);
    chk("bypass_dat", rd_data,  32'h9);
    for (int i = 0; i < 4; i++) step();
    chk("t4_sel4", rd_sel,  32'h4);
    chk("t4_dat4", rd_data, 32'h5);

    // 4: clr at scan index 4 aborts without rd_done
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_abort_rv",  rd_valid, 32'h0);
    chk("t4_abort_bus", out_bus,  32'h0);
    chk("t4_abort_rdy", in_ready, 32'h1);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rd_done || rd_valid) seen_done = 1'b1;
      step();
    end
    chk("t4_no_done", seen_done, 32'h0);

    // clr beats a simultaneous write
    in_valid = 1'b1; flag = 3'd1; in_data = 4'h3;
    step();
    chk("t4_pre_bus", out_bus, 32'h0000_0030);
    clr = 1'b1; flag = 3'd2; in_data = 4'h7;
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("t4_clr_bus", out_bus, 32'h0);
    chk("t4_clr_upd", out_upd, 32'h0);

    // clr blocks scan_start in IDLE
    clr = 1'b1; scan_start = 1'b1;
    step();
    clr = 1'b0; scan_start = 1'b0;
    chk("t4_clr_scan_rv",  rd_valid, 32'h0);
    chk("t4_clr_scan_rdy", in_ready, 32'h1);

    // 5: async reset between edges mid-scan
    in_valid = 1'b1; flag = 3'd7; in_data = 4'hC;
    step();
    in_valid = 1'b0;
    chk("t5_pre_bus", out_bus, 32'hC000_0000);
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step(); step();
    chk("t5_mid_sel", rd_sel, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    #2 rst_n = 1'b1;
    step();
    chk("t5_post_rv",  rd_valid, 32'h0);
    chk("t5_post_rdy", in_ready, 32'h1);

`ifdef DEMUX_STATUS_EN
    // 6: sticky mask and saturating overwrite counter
    chk("t6_rst_mask", wr_mask, 32'h0);
    chk("t6_rst_ovw",  ovw_cnt, 32'h0);
    in_valid = 1'b1; in_data = 4'h1;
    flag = 3'd1; step();
    flag = 3'd1; step();
    flag = 3'd6; step();
    in_valid = 1'b0;
    chk("t6_mask", wr_mask, 32'h42);
    chk("t6_ovw",  ovw_cnt, 32'h1);
    in_valid = 1'b1; flag = 3'd6;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    chk("t6_sat", ovw_cnt, 32'hFF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t6_clr_mask", wr_mask, 32'h0);
    chk("t6_clr_ovw",  ovw_cnt, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
